periph_bus_resp: RTL and testbench

- Memory-mapped peripheral responder on the single-cycle CPU's data bus. The CPU is the initiator; this block answers its loads and stores.
- Owns the board I/O: LEDs, switches and the 4-digit 7-segment display (oDigi). Also contains a 32-bit reload timer with an interrupt.
- Sits beside data memory. The CPU routes any access whose address falls in BASE_ADDR..BASE_ADDR+0x1F here.

---
 rtl/periph_pkg.sv | 24 ++
 rtl/seg7_hex_dec.sv | 14 +
 rtl/periph_bus_resp.sv | 141 ++++++++++++++
 tb/tb_periph_bus_resp.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared constants for the peripheral bus responder: register offsets, TCON bit
// positions, the active-low 7-segment table and the display digit count.
package periph_pkg;

    localparam logic [2:0] OFS_TH     = 3'd0;
    localparam logic [2:0] OFS_TL     = 3'd1;
    localparam logic [2:0] OFS_TCON   = 3'd2;
    localparam logic [2:0] OFS_LED    = 3'd3;
    localparam logic [2:0] OFS_SWITCH = 3'd4;
    localparam logic [2:0] OFS_DIGI   = 3'd5;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    localparam int NUM_DIGITS = 4;

    // Segment patterns {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex-to-7-segment decoder (active-low gfedcba).
// Only built when PERIPH_HEX_SCAN_EN is defined, since only the scan display uses it.
`ifdef PERIPH_HEX_SCAN_EN
module seg7_hex_dec
    import periph_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule
`endif

// File: rtl/periph_bus_resp.sv
// Memory-mapped peripheral responder: reload timer with interrupt, LEDs, switches and
// 7-segment display. Define PERIPH_HEX_SCAN_EN for the multiplexed hex-scan display.
module periph_bus_resp
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          SCAN_DIV  = 50000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iAddr,
    input  logic        iWrEn,
    input  logic [31:0] iWrData,
    input  logic        iRdEn,
    output logic [31:0] oRdData,
    input  logic [7:0]  iSwitch,
    output logic [7:0]  oLED,
    output logic [11:0] oDigi,
    output logic        oIrq
);

`ifdef PERIPH_HEX_SCAN_EN
    localparam int DIGI_W = 16;
`else
    localparam int DIGI_W = 12;
`endif

    logic [31:0]       th;
    logic [31:0]       tl;
    logic [2:0]        tcon;
    logic [7:0]        led;
    logic [DIGI_W-1:0] digi;
    logic [7:0]        swSync1;
    logic [7:0]        swSync2;
    logic              hit;
    logic              wrAccess;
    logic [2:0]        ofs;
    logic              tlMax;
    logic              timerEn;
    logic [1:0]        unusedAddrBits;

    assign hit            = (iAddr[31:5] == BASE_ADDR[31:5]);
    assign ofs            = iAddr[4:2];
    assign wrAccess       = hit & iWrEn;
    assign tlMax          = (tl == 32'hFFFF_FFFF);
    assign timerEn        = tcon[TCON_EN];
    assign unusedAddrBits = iAddr[1:0];

    // A CPU store to TL or TCON overrides the timer's own update of that register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            led     <= '0;
            digi    <= '0;
            swSync1 <= '0;
            swSync2 <= '0;
        end else begin
            if (wrAccess && ofs == OFS_TH)
                th <= iWrData;
            if (wrAccess && ofs == OFS_TL)
                tl <= iWrData;
            else if (timerEn)
                tl <= tlMax ? th : tl + 32'd1;
            if (wrAccess && ofs == OFS_TCON)
                tcon <= iWrData[2:0];
            else if (timerEn && tlMax && tcon[TCON_IE])
                tcon[TCON_ST] <= 1'b1;
            if (wrAccess && ofs == OFS_LED)
                led <= iWrData[7:0];
            if (wrAccess && ofs == OFS_DIGI)
                digi <= iWrData[DIGI_W-1:0];
            swSync1 <= iSwitch;
            swSync2 <= swSync1;
        end
    end

    assign oLED = led;
    assign oIrq = tcon[TCON_IE] & tcon[TCON_ST];

    always_comb begin
        oRdData = '0;
        if (hit && iRdEn) begin
            case (ofs)
                OFS_TH:     oRdData = th;
                OFS_TL:     oRdData = tl;
                OFS_TCON:   oRdData = {29'd0, tcon};
                OFS_LED:    oRdData = {24'd0, led};
                OFS_SWITCH: oRdData = {24'd0, swSync2};
                OFS_DIGI:   oRdData = 32'(digi);
                default:    oRdData = '0;
            endcase
        end
    end

`ifdef PERIPH_HEX_SCAN_EN
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] scanCnt;
    logic [IDX_W-1:0] digitIdx;
    logic [3:0]       curNibble;
    logic [6:0]       curSeg;

    assign curNibble = digi[{digitIdx, 2'b00} +: 4];

    seg7_hex_dec uDec (
        .hex (curNibble),
        .seg (curSeg)
    );

    // The scan keeps running across DIGI writes; new digits appear on their next refresh.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            scanCnt  <= '0;
            digitIdx <= '0;
            oDigi    <= 12'hFFF;
        end else begin
            oDigi <= {~(4'b0001 << digitIdx), 1'b1, curSeg};
            if (scanCnt == CNT_W'(SCAN_DIV - 1)) begin
                scanCnt  <= '0;
                digitIdx <= digitIdx + IDX_W'(1);
            end else begin
                scanCnt <= scanCnt + CNT_W'(1);
            end
        end
    end
`else
    localparam int unusedScanDiv = SCAN_DIV;

    // Direct mode: the display stays blank until software first writes DIGI.
    always_ff @(posedge iClk) begin
        if (iRst)
            oDigi <= 12'hFFF;
        else if (wrAccess && ofs == OFS_DIGI)
            oDigi <= iWrData[11:0];
    end
`endif

endmodule

// File: tb/tb_periph_bus_resp.sv
// Self-checking bench for periph_bus_resp: directed steps plus a randomized phase,
// compared against a behavioural model of the register map, timer and display.
module tb_periph_bus_resp;

    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam int          SCAN_TB = 4;
`ifdef PERIPH_HEX_SCAN_EN
    localparam logic [31:0] DIGI_MASK = 32'h0000_FFFF;
`else
    localparam logic [31:0] DIGI_MASK = 32'h0000_0FFF;
`endif

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [31:0] iAddr = '0;
    logic        iWrEn = 1'b0;
    logic [31:0] iWrData = '0;
    logic        iRdEn = 1'b0;
    logic [31:0] oRdData;
    logic [7:0]  iSwitch = '0;
    logic [7:0]  oLED;
    logic [11:0] oDigi;
    logic        oIrq;

    int checks = 0;
    int errors = 0;

    logic [31:0] mTh, mTl, mDigi;
    logic [2:0]  mTcon;
    logic [7:0]  mLed, mSw1, mSw2;
    logic [11:0] mDigiOut, mHexOut;
    int          mEdges;

    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    periph_bus_resp #(.BASE_ADDR(BASE), .SCAN_DIV(SCAN_TB)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iAddr   (iAddr),
        .iWrEn   (iWrEn),
        .iWrData (iWrData),
        .iRdEn   (iRdEn),
        .oRdData (oRdData),
        .iSwitch (iSwitch),
        .oLED    (oLED),
        .oDigi   (oDigi),
        .oIrq    (oIrq)
    );

    always #5 iClk = ~iClk;

    function automatic logic [11:0] hexFrame(input int pos, input logic [31:0] d);
        int         digit;
        logic [3:0] nib;
        logic [3:0] anode;
        digit = (pos / SCAN_TB) % 4;
        nib   = d[digit*4 +: 4];
        anode = 4'b1111 ^ (4'b0001 << digit);
        return {anode, 1'b1, segTab[nib]};
    endfunction

    function automatic logic [31:0] expectedRead();
        if (!iRdEn || iAddr[31:5] != BASE[31:5]) return 32'd0;
        case (iAddr[4:2])
            3'd0:    return mTh;
            3'd1:    return mTl;
            3'd2:    return {29'd0, mTcon};
            3'd3:    return {24'd0, mLed};
            3'd4:    return {24'd0, mSw2};
            3'd5:    return mDigi;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [11:0] expectedDigi();
`ifdef PERIPH_HEX_SCAN_EN
        return mHexOut;
`else
        return mDigiOut;
`endif
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".led"},  {24'd0, oLED},  {24'd0, mLed});
        checkValue({tag, ".irq"},  {31'd0, oIrq},  {31'd0, mTcon[1] & mTcon[2]});
        checkValue({tag, ".digi"}, {20'd0, oDigi}, {20'd0, expectedDigi()});
        checkValue({tag, ".rd"},   oRdData,        expectedRead());
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                                 input logic [31:0] data, input logic rd);
        iAddr   = addr;
        iWrEn   = wr;
        iWrData = data;
        iRdEn   = rd;
        #1;
    endtask

    // Advance one clock and move the model forward using the inputs held across the edge.
    task automatic clockStep();
        logic        cRst, cWr;
        logic [31:0] cAddr, cData, nTl;
        logic [2:0]  nTcon;
        logic [7:0]  cSw;
        cRst = iRst; cWr = iWrEn; cAddr = iAddr; cData = iWrData; cSw = iSwitch;
        @(posedge iClk);
        #1;
        if (cRst) begin
            mTh = 0; mTl = 0; mTcon = 0; mLed = 0; mDigi = 0;
            mSw1 = 0; mSw2 = 0; mDigiOut = 12'hFFF; mHexOut = 12'hFFF; mEdges = 0;
        end else begin
            nTl   = mTl;
            nTcon = mTcon;
            if (mTcon[0]) begin
                if (mTl == 32'hFFFF_FFFF) begin
                    nTl = mTh;
                    if (mTcon[1]) nTcon[2] = 1'b1;
                end else begin
                    nTl = mTl + 1;
                end
            end
            mHexOut = hexFrame(mEdges, mDigi);
            mEdges++;
            if (cWr && cAddr[31:5] == BASE[31:5]) begin
                case (cAddr[4:2])
                    3'd0: mTh = cData;
                    3'd1: nTl = cData;
                    3'd2: nTcon = cData[2:0];
                    3'd3: mLed = cData[7:0];
                    3'd5: begin mDigi = cData & DIGI_MASK; mDigiOut = cData[11:0]; end
                    default: ;
                endcase
            end
            mSw2  = mSw1;
            mSw1  = cSw;
            mTl   = nTl;
            mTcon = nTcon;
        end
    endtask

    task automatic tick(input string tag);
        clockStep();
        checkOutput(tag);
    endtask

    initial begin
        logic [31:0] addr, data;
        logic        wr, rd;

        // Reset behaviour
        applyStimulus(BASE, 1'b0, 0, 1'b0);
        tick("reset0");
        tick("reset1");
        checkValue("resetLed",  {24'd0, oLED},  32'd0);
        checkValue("resetDigi", {20'd0, oDigi}, 32'h0000_0FFF);
        checkValue("resetIrq",  {31'd0, oIrq},  32'd0);
        iRst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(BASE + 32'(i * 4), 1'b0, 0, 1'b1);
            tick("idleRead");
        end

        // Timer reload and interrupt
        applyStimulus(BASE + 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0); tick("wrTh");
        applyStimulus(BASE + 32'h4, 1'b1, 32'hFFFF_FFFE, 1'b0); tick("wrTl");
        applyStimulus(BASE + 32'h8, 1'b1, 32'd3, 1'b0);         tick("wrTcon");
        applyStimulus(BASE + 32'h4, 1'b0, 0, 1'b1);
        checkValue("tlStart", oRdData, 32'hFFFF_FFFE);
        tick("timer1");
        checkValue("tlPlus1", oRdData, 32'hFFFF_FFFF);
        checkValue("irqLow",  {31'd0, oIrq}, 32'd0);
        tick("timer2");
        checkValue("tlReload", oRdData, 32'hFFFF_FFFC);
        checkValue("irqRise",  {31'd0, oIrq}, 32'd1);
        tick("timer3");
        checkValue("irqHold", {31'd0, oIrq}, 32'd1);
        applyStimulus(BASE + 32'h8, 1'b1, 32'd3, 1'b1); tick("clrStatus");
        checkValue("irqClear", {31'd0, oIrq}, 32'd0);
        checkValue("tconRead", oRdData, 32'd3);

        // CPU write to TL on the overflow edge wins over the reload
        applyStimulus(BASE + 32'h4, 1'b1, 32'hFFFF_FFFF, 1'b0); tick("tlMax");
        applyStimulus(BASE + 32'h4, 1'b1, 32'd5, 1'b0);         tick("collide");
        applyStimulus(BASE + 32'h4, 1'b0, 0, 1'b1);
        checkValue("collideTl",  oRdData, 32'd5);
        checkValue("collideIrq", {31'd0, oIrq}, 32'd1);
        applyStimulus(BASE + 32'h8, 1'b1, 32'd0, 1'b0); tick("timerOff");

        // Switch synchroniser and LEDs
        iSwitch = 8'hA5;
        applyStimulus(BASE + 32'h10, 1'b0, 0, 1'b1);
        tick("sw1");
        checkValue("swEdge1", oRdData, 32'd0);
        tick("sw2");
        checkValue("swEdge2", oRdData, 32'h0000_00A5);
        applyStimulus(BASE + 32'h0C, 1'b1, 32'h0000_003C, 1'b0); tick("ledWr");
        checkValue("ledOut", {24'd0, oLED}, 32'h0000_003C);
        applyStimulus(BASE + 32'h10, 1'b1, 32'h0000_0011, 1'b1); tick("swWr");
        checkValue("swReadOnly", oRdData, 32'h0000_00A5);

        // Address decode
        applyStimulus(BASE + 32'h18, 1'b1, 32'hFFFF_FFFF, 1'b1);
        checkValue("unmappedRd", oRdData, 32'd0);
        tick("unmappedWr");
        applyStimulus(32'h5000_000C, 1'b1, 32'h0000_00FF, 1'b1);
        checkValue("missRd", oRdData, 32'd0);
        tick("missWr");
        checkValue("missLed", {24'd0, oLED}, 32'h0000_003C);
        applyStimulus(BASE + 32'h0C, 1'b0, 0, 1'b0);
        checkValue("rdDisabled", oRdData, 32'd0);

        // Display
`ifdef PERIPH_HEX_SCAN_EN
        iRst = 1'b1;
        applyStimulus(BASE, 1'b0, 0, 1'b0); tick("scanRst");
        iRst = 1'b0;
        applyStimulus(BASE + 32'h14, 1'b1, 32'h0000_1234, 1'b0); tick("digiWr");
        checkValue("scanFirst", {20'd0, oDigi}, 32'h0000_0EC0);
        applyStimulus(BASE + 32'h14, 1'b0, 0, 1'b1);
        tick("scan2");
        checkValue("scanDigit0", {20'd0, oDigi}, 32'h0000_0E99);
        tick("scan3");
        tick("scan4");
        tick("scan5");
        checkValue("scanDigit1", {20'd0, oDigi}, 32'h0000_0DB0);
        for (int i = 0; i < 14; i++) tick("scanRun");
        iRst = 1'b1;
        applyStimulus(BASE + 32'h14, 1'b1, 32'h0000_FFFF, 1'b0); tick("scanMidRst");
        checkValue("scanRstDigi", {20'd0, oDigi}, 32'h0000_0FFF);
        iRst = 1'b0;
`else
        applyStimulus(BASE + 32'h14, 1'b1, 32'hFFFF_FABC, 1'b1); tick("digiWr");
        checkValue("digiOut",  {20'd0, oDigi}, 32'h0000_0ABC);
        checkValue("digiRead", oRdData, 32'h0000_0ABC);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            iRst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) iSwitch = 8'($urandom);
            addr = ($urandom_range(0, 9) != 0) ? (BASE | 32'($urandom_range(0, 7) << 2)) : $urandom;
            wr   = $urandom_range(0, 1) == 1;
            rd   = $urandom_range(0, 3) != 0;
            data = $urandom;
            if (addr[4:2] == 3'd1 && $urandom_range(0, 1) == 1)
                data = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            if (addr[4:2] == 3'd2)
                data = 32'($urandom_range(0, 7)) | 32'h1;
            applyStimulus(addr, wr, data, rd);
            tick("random");
        end

        // Reset with a concurrent store
        iRst = 1'b1;
        applyStimulus(BASE + 32'h0C, 1'b1, 32'h0000_00FF, 1'b1); tick("finalRst");
        checkValue("finalLed",  {24'd0, oLED},  32'd0);
        checkValue("finalDigi", {20'd0, oDigi}, 32'h0000_0FFF);
        checkValue("finalIrq",  {31'd0, oIrq},  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
